// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the multi-cycle mul/div unit.
// State encoding, op-select constants and the conditional-negate helper.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  function automatic logic [MD_WIDTH-1:0] cond_neg(
    input logic [MD_WIDTH-1:0] x,
    input logic                en
  );
    return en ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 signed/unsigned multiplier and restoring divider.
// Magnitudes are iterated, signs are applied in a single fix-up cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  localparam int W2 = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             pend_q, pend_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [W2-1:0]    acc_q, acc_d;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   rw;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    add_s = {1'b0, acc_q[W2-1:WIDTH]}
          + (acc_q[0] ? {1'b0, a_q} : '0);
    rw    = acc_q[W2-1:WIDTH-1];
    diff  = rw - {1'b0, b_q};
    if (div_q) begin
      if (diff[WIDTH]) begin
        step = {rw[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step = {add_s, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    pend_d    = pend_q;
    dbz_d     = dbz_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    a_mag     = cond_neg(a_in, op_signed & a_in[WIDTH-1]);
    b_mag     = cond_neg(b_in, op_signed & b_in[WIDTH-1]);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          div_d     = (op_div == MD_DIV);
          neg_res_d = op_signed
                    & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
          neg_rem_d = op_signed & a_in[WIDTH-1];
          dbz_d     = 1'b0;
          cnt_d     = '0;
          if (op_div == MD_DIV && b_in == '0) begin
            a_d     = a_in;
            b_d     = '0;
            acc_d   = '0;
            pend_d  = 1'b1;
            state_d = DONE;
          end else begin
            a_d     = a_mag;
            b_d     = b_mag;
            acc_d   = {{WIDTH{1'b0}},
                       (op_div == MD_DIV) ? a_mag : b_mag};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (div_q) begin
          lo_d = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
          hi_d = cond_neg(acc_q[W2-1:WIDTH], neg_rem_q);
        end else begin
          {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (pend_q) begin
          hi_d   = a_q;
          lo_d   = '1;
          dbz_d  = 1'b1;
          pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      pend_q    <= 1'b0;
      dbz_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      pend_q    <= pend_d;
      dbz_q     <= dbz_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
    end
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE) && !pend_q;
  assign div_by_zero = dbz_q;
  assign result_hi   = hi_q;
  assign result_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results and timing.
// Latency counts cycles from the accept cycle to the done cycle.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic        op_signed = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] result_hi;
  logic [31:0] result_lo;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .op_div     (op_div),
    .op_signed  (op_signed),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .result_hi  (result_hi),
    .result_lo  (result_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic accept(
    input logic        d,
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    op_div    = d;
    op_signed = s;
    a_in      = a;
    b_in      = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = 32'hdead_beef;
    b_in  = 32'h1234_5678;
  endtask

  task automatic run(
    input string       tag,
    input logic        d,
    input logic        s,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] ehi,
    input logic [31:0] elo,
    input int          elat,
    input int          ebusy,
    input logic        edz
  );
    int lat;
    int bc;
    lat = 0;
    bc  = 0;
    accept(d, s, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        lat = i + 1;
        break;
      end
    end
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".busy"}, bc, ebusy);
    chk({tag, ".hi"}, result_hi, ehi);
    chk({tag, ".lo"}, result_lo, elo);
    chk({tag, ".dbz"}, {31'b0, div_by_zero}, {31'b0, edz});
    @(negedge clk);
    chk({tag, ".pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int dcnt;

    #23;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.dbz", {31'b0, div_by_zero}, 32'd0);
    chk("rst.hi", result_hi, 32'd0);
    chk("rst.lo", result_lo, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    run("smul7x-3", 1'b0, 1'b1, 32'd7, 32'hffff_fffd,
        32'hffff_ffff, 32'hffff_ffeb, 34, 33, 1'b0);
    run("umul_ff", 1'b0, 1'b0, 32'hffff_ffff, 32'hffff_ffff,
        32'hffff_fffe, 32'h0000_0001, 34, 33, 1'b0);
    run("smul_ff", 1'b0, 1'b1, 32'hffff_ffff, 32'hffff_ffff,
        32'h0, 32'h1, 34, 33, 1'b0);
    run("smul_min", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 32'h0, 34, 33, 1'b0);
    run("sdiv-7/2", 1'b1, 1'b1, 32'hffff_fff9, 32'd2,
        32'hffff_ffff, 32'hffff_fffd, 34, 33, 1'b0);
    run("sdiv7/-2", 1'b1, 1'b1, 32'd7, 32'hffff_fffe,
        32'd1, 32'hffff_fffd, 34, 33, 1'b0);
    run("udiv100/7", 1'b1, 1'b0, 32'd100, 32'd7,
        32'd2, 32'd14, 34, 33, 1'b0);
    run("udiv_big", 1'b1, 1'b0, 32'hffff_fff9, 32'd2,
        32'd1, 32'h7fff_fffc, 34, 33, 1'b0);
    run("dbz5", 1'b1, 1'b0, 32'd5, 32'd0,
        32'd5, 32'hffff_ffff, 2, 0, 1'b1);
    run("dbz-5", 1'b1, 1'b1, 32'hffff_fffb, 32'd0,
        32'hffff_fffb, 32'hffff_ffff, 2, 0, 1'b1);

    accept(1'b1, 1'b1, 32'h8000_0000, 32'hffff_ffff);
    chk("dbz.clr", {31'b0, div_by_zero}, 32'd0);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i + 1;
        break;
      end
    end
    chk("min/-1.lat", lat, 34);
    chk("min/-1.lo", result_lo, 32'h8000_0000);
    chk("min/-1.hi", result_hi, 32'h0);
    chk("min/-1.dbz", {31'b0, div_by_zero}, 32'd0);

    accept(1'b0, 1'b1, 32'd6, 32'd7);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 5) begin
        start     = 1'b1;
        op_div    = 1'b1;
        op_signed = 1'b0;
        a_in      = 32'd100;
        b_in      = 32'd3;
      end else if (i == 6) begin
        start = 1'b0;
      end
      if (done) begin
        lat = i + 1;
        break;
      end
    end
    chk("ign.lat", lat, 34);
    chk("ign.hi", result_hi, 32'd0);
    chk("ign.lo", result_lo, 32'd42);

    @(negedge clk);
    accept(1'b0, 1'b0, 32'd11, 32'd13);
    for (int i = 0; i < 10; i++) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("abort.busy", {31'b0, busy}, 32'd0);
    chk("abort.done", {31'b0, done}, 32'd0);
    chk("abort.hi", result_hi, 32'd0);
    chk("abort.lo", result_lo, 32'd0);
    repeat (2) @(negedge clk);
    clr  = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort.nodone", dcnt, 0);

    run("mul3x4", 1'b0, 1'b0, 32'd3, 32'd4,
        32'd0, 32'd12, 34, 33, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle signed/unsigned 32x32 multiplier and divider.
- Sits beside the ALU and feeds the datapath's Z_HI/Z_LO register pair.
- Operand A comes from Y_Data and operand B from bus_Data.
- The control unit starts an operation, waits for done, then asserts Z_enable; the 64-bit result is presented as {result_hi, result_lo}.

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH split into hi/lo halves.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- op_div  in  1  0 = multiply, 1 = divide; captured with start.
- op_signed  in  1  1 = two's-complement operands; captured with start.
- a_in  in  WIDTH  multiplicand / dividend.
- b_in  in  WIDTH  multiplier / divisor.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse; result valid from this cycle on.
- div_by_zero  out  1  valid with done; held until the next accepted start.
- result_hi  out  WIDTH  mul: upper product; div: remainder.
- result_lo  out  WIDTH  mul: lower product; div: quotient.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (clr=0): state IDLE; busy, done, div_by_zero = 0; result_hi, result_lo = 0; counter, accumulators and captured operands = 0.
- Reset mid-operation: aborts immediately; no done is emitted.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge k:
  - Capture op_div and op_signed.
  - Capture |a_in| and |b_in|; magnitudes are taken only if op_signed=1.
  - Record neg_res and neg_rem.
  - Counter = 0; go to CALC.
  - div_by_zero is cleared at this edge.
- IDLE, start=1 with op_div=1 and b_in=0:
  - Go straight to DONE at edge k.
  - Next edge sets result_hi = a_in (raw), result_lo = all ones, div_by_zero = 1.
  - done is high in the cycle after edge k+1.
- CALC: one iteration per cycle, WIDTH iterations; leave for FIX when counter = WIDTH-1.
  - Multiply: shift-add on unsigned magnitudes into a 2*WIDTH product register.
  - Divide: restoring division; shift remainder/quotient left, trial-subtract the divisor, set the quotient bit if no borrow.
- FIX (one cycle):
  - Multiply: if neg_res, negate the 2*WIDTH product.
  - Divide: if neg_res (dividend sign XOR divisor sign), negate the quotient. If neg_rem (dividend negative), negate the remainder.
  - Quotient truncates toward zero; the remainder carries the dividend's sign.
  - Load result_hi and result_lo; go to DONE.
- DONE (one cycle): done = 1, busy = 0, then IDLE. A start in this cycle is ignored; it is accepted only in IDLE.
- Latency: start accepted at edge k gives done high in the cycle after edge k+WIDTH+1 (34 cycles for WIDTH=32). Divide-by-zero latency is 2.
- busy: 1 in CALC and FIX only.
- start while not IDLE: ignored, with no effect on captured operands.
- Result outputs hold their value until the next FIX or divide-by-zero load. Operand inputs may change after the accept edge.
- Signed INT_MIN / -1: magnitude arithmetic gives quotient 0x80000000 and remainder 0; no overflow flag.
- Signed multiply of INT_MIN * INT_MIN = 0x40000000_00000000.
- Unsigned mode never negates.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE, CALC, FIX, DONE.
  - Op-select constants: MD_MUL, MD_DIV.
  - WIDTH default.
  - A negate/absolute-value function used by both the FIX stage and operand capture.
- No sub-module required. Optionally, muldiv_iter (one combinational shift-add / trial-subtract step) may be split out for reuse by a later radix-4 version.

Test Plan:
1. Signed multiply, a=7, b=-3 (0xFFFFFFFD) -> done exactly 34 cycles after the accept edge; result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB; busy high for 33 cycles.
2. Unsigned multiply, a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001. Same operands signed -> hi=0, lo=1.
3. Signed divide, a=-7 (0xFFFFFFF9), b=2 -> result_lo=0xFFFFFFFD (-3), result_hi=0xFFFFFFFF (-1). Unsigned 100/7 -> lo=14, hi=2.
4. Divide by zero, a=5, b=0 -> done 2 cycles after the accept edge; div_by_zero=1, result_hi=5, result_lo=0xFFFFFFFF. The next valid start clears div_by_zero.
5. Signed divide, 0x80000000 / 0xFFFFFFFF -> result_lo=0x80000000, result_hi=0; div_by_zero=0.
6. Start pulsed again at iteration 5 with different operands -> ignored; the original result is delivered. Then clr low at iteration 10 -> busy=0, results=0 immediately, no done. After release, a new multiply 3*4 -> lo=12 at 34 cycles.
